aes_cipher_iter: RTL
====================

# aes_cipher_iter

Iterative AES forward cipher (FIPS-197 encryption) that runs one round per clock over a single 128-bit state register. It is the encryption-direction counterpart of the decryption datapath. It consumes the same packed, externally expanded key schedule, so a block encrypted here round-trips through the decryption path unchanged. It sits between the key-expansion block and the system's block-transfer logic, using valid/ready handshakes on both sides.

## Interface
- Nk, 4: key length in 32-bit words (4/6/8).
- Nr, 10: number of rounds (10/12/14). Must equal Nk+6.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  128  plaintext block. in[127:120] is byte 0 (s[0,0]); bytes run column-major.
- in_valid  input  1  plaintext offered.
- in_ready  output  1  block can accept plaintext.
- key_out  input  128*(Nr+1)  expanded key schedule. Round key i is key_out[128*(i+1)-1 -: 128].
- out  output  128  ciphertext, same byte order as in.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.

## Operation
- FSM states: IDLE, ROUND, DONE. A 4-bit round counter rnd runs 1..Nr.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state <= in ^ rk[0], rnd <= 1, go to ROUND.
- ROUND:
  - Each cycle: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[rnd]).
  - MixColumns is bypassed when rnd==Nr.
  - rnd<Nr: rnd <= rnd+1.
  - rnd==Nr: out <= result, out_valid <= 1, go to DONE.
- DONE:
  - out and out_valid hold until out_valid&&out_ready, then out_valid <= 0 and go to IDLE.
  - out keeps its last value after the handshake.
- in_ready is 0 in ROUND and DONE. in_valid is ignored there, and in is not sampled.
- key_out is not registered. It must stay stable from plaintext acceptance through the final ROUND cycle. Changing it mid-operation gives undefined ciphertext; this is a caller obligation, covered by an assertion in the bench.
- in is sampled only on the accept edge and may change afterward.
- SubBytes uses the forward S-box: 16 parallel instances, combinational.
- MixColumns multiplies over GF(2^8) with polynomial 0x11B, using xtime.
- ShiftRows rotates row r left by r bytes.
- Nr must be 10/12/14 and Nk=Nr-6. Any other value is a configuration error, flagged by elaboration-time check.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM to IDLE, rnd=0, state=0.
  - out=0, out_valid=0, in_ready=1 once reset deasserts. in_ready is 0 while rst_n is low.
- Latency: the accept edge is edge k; out_valid rises after edge k+Nr. That is 10/12/14 cycles for AES-128/192/256.
- Minimum issue interval is Nr+2 cycles:
  - Consumer holds out_ready=1, so the handshake happens on edge k+Nr+1.
  - IDLE then holds in_ready=1 during the following cycle.
  - The next accept is edge k+Nr+2.
- Backpressure: out_valid stays high and out stays bit-stable for any number of cycles while out_ready=0.
- Reset asserted in ROUND or DONE aborts immediately: out_valid drops and the in-flight block is discarded.
- out_ready while out_valid=0 has no effect.
- Datapath critical path: SubBytes → ShiftRows → MixColumns → XOR, all in one cycle.

## Test plan
- AES-128 (Nk=4, Nr=10), FIPS-197 C.1:
  - Stimulus: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, out_ready=1.
  - Response: out=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid first high 10 cycles after accept, for exactly 1 cycle.
- AES-256 (Nk=8, Nr=14), C.3:
  - Stimulus: same pt, key 000102…1f.
  - Response: out=8ea2b7ca516745bfeafc49904b496089; latency 14 cycles.
- Backpressure and busy:
  - Stimulus: FIPS-197 App. B (pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c); out_ready=0 for 20 cycles; in_valid kept high with a different block throughout.
  - Response: out stays 3925841d02dc09fbdc118597196a0b32; in_ready=0; second block accepted only on the first cycle after the output handshake.
- Reset mid-round:
  - Stimulus: pulse rst_n low asynchronously (between clock edges) at round 5.
  - Response: out_valid=0 and out=0 immediately; in_ready=1 after release; the next C.1 block gives the correct ciphertext.
- Round trip:
  - Stimulus: 1000 random pt/key pairs (Nr=10,12,14); each ciphertext fed into the decryption path with the same expanded schedule.
  - Response: recovered pt equals the original; every ciphertext matches the reference model.
- Back-to-back: with out_ready=1 and in_valid=1 continuously, accepts occur exactly every Nr+2 cycles.

Source files
------------

// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher: one full round per clock over a single 128-bit state register.
// Round keys are taken live from an externally expanded schedule that must stay stable while busy.
module aes_cipher_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [127:0]          in_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [128*(Nr+1)-1:0] key_out_i,
    output logic [127:0]          out_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [1:0]            dbg_state_o
);
    if (!((Nr == 10 || Nr == 12 || Nr == 14) && Nk == Nr - 6)) begin : g_bad_cfg
        $error("aes_cipher_iter: Nr must be 10, 12 or 14 and Nk must equal Nr-6");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready, and a raised out_valid holds with out stable until it is taken.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    localparam logic [3:0] LAST_RND = 4'(Nr);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] rk, sb, sr, mc, rnd_res;
    logic         last_rnd;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Forward S-box as inversion a^254 (square-and-multiply) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte (r,c) of a block lives at bit 127-8*(r+4c); columns are 32-bit slices.
    always_comb begin
        for (int b = 0; b < 16; b++) sb[8*b +: 8] = sbox(blk_q[8*b +: 8]);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    assign rk       = key_out_i[{rnd_q, 7'd0} +: 128];
    assign last_rnd = (rnd_q == LAST_RND);
    assign rnd_res  = (last_rnd ? sr : mc) ^ rk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= S_IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            S_IDLE:  if (in_valid_i)  fsm_d = S_ROUND;
            S_ROUND: if (last_rnd)    fsm_d = S_DONE;
            S_DONE:  if (out_ready_i) fsm_d = S_IDLE;
            default:                  fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = rst_n && (fsm_q == S_IDLE);
        out_o       = out_q;
        out_valid_o = out_valid_q;
        dbg_state_o = fsm_q;
    end

    always_comb begin
        blk_d       = blk_q;
        rnd_d       = rnd_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    blk_d = in_i ^ key_out_i[127:0];
                    rnd_d = 4'd1;
                end
            end
            S_ROUND: begin
                blk_d = rnd_res;
                if (last_rnd) begin
                    out_d       = rnd_res;
                    out_valid_d = 1'b1;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready_i) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q       <= 4'd0;
            blk_q       <= 128'd0;
            out_q       <= 128'd0;
            out_valid_q <= 1'b0;
        end else begin
            rnd_q       <= rnd_d;
            blk_q       <= blk_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
